// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch prefetch unit: default widths,
// the decode bubble encoding and the prefetch queue entry layout.
package fetch_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] BUBBLE_INSTR     = 32'h0000_0000;

  // Queue entries are XLEN_DEFAULT wide, so the fetch unit is built for XLEN = 32
  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: power-of-two circular buffer with wrap-around pointers,
// occupancy count and a flush that empties it in one cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         empty
);

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] PTR_ZERO = PW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == CNT_ZERO);
  assign full    = (count == CNT_FULL);
  assign do_pop  = pop && !empty;
  assign do_push = push && !full;
  assign head    = mem[rd_ptr];

  // Storage array, written on push only
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= PTR_ZERO;
      rd_ptr <= PTR_ZERO;
      count  <= CNT_ZERO;
    end else if (flush) begin
      wr_ptr <= PTR_ZERO;
      rd_ptr <= PTR_ZERO;
      count  <= CNT_ZERO;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  fetch_fifo_checker u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .full  (full)
  );

endmodule

// File: rtl/fetch_fifo_checker.sv
// Protocol checks for the prefetch queue; holds no synthesizable state.
module fetch_fifo_checker (
  input logic clk,
  input logic rst_n,
  input logic flush,
  input logic push,
  input logic full
);

  // The credit scheme must never let a response arrive into a full queue
  a_no_push_on_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !flush));

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction fetch with a credit-limited prefetch queue, in-order response
// tagging, stale-response dropping after redirects, and the decode register.
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pcselE,
  input  logic [XLEN-1:0] pcTargetE,
  input  logic            stallF,
  input  logic            stallD,
  input  logic            flushD,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic [XLEN-1:0] pcF,
  output logic [XLEN-1:0] instrD,
  output logic [XLEN-1:0] pcD,
  output logic [XLEN-1:0] pc4D,
  output logic            validD
);

  localparam int              CW        = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]   CNT_ZERO  = CW'(0);
  localparam logic [CW:0]     CREDIT    = (CW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
  localparam logic [XLEN-1:0] PC_ZERO   = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] BUBBLE    = XLEN'(BUBBLE_INSTR);

  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   outstanding_nxt;
  logic [CW-1:0]   drop_cnt_nxt;
  logic [CW:0]     in_flight;
  logic [XLEN-1:0] target_aligned;
  logic            accept;
  logic            push;
  logic            pop;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;

  logic [XLEN-1:0] instr_nxt;
  logic [XLEN-1:0] pc_nxt;
  logic [XLEN-1:0] pc4_nxt;
  logic            valid_nxt;

  assign in_flight      = {1'b0, fifo_count} + {1'b0, outstanding};
  assign imem_req_valid = rst_n && !stallF && !pcselE && (in_flight < CREDIT);
  assign imem_req_addr  = pcF;
  assign accept         = imem_req_valid && imem_req_ready;
  assign target_aligned = {pcTargetE[XLEN-1:2], 2'b00};

  assign push       = imem_rsp_valid && (drop_cnt == CNT_ZERO) && !pcselE;
  assign pop        = !pcselE && !flushD && !stallD && !fifo_empty;
  assign push_entry = '{pc: rsp_pc, instr: imem_rsp_data};

  // Request/response credit and stale-response accounting
  always_comb begin
    outstanding_nxt = outstanding;
    drop_cnt_nxt    = drop_cnt;
    if (accept && !imem_rsp_valid) begin
      outstanding_nxt = outstanding + CNT_ONE;
    end else if (!accept && imem_rsp_valid) begin
      outstanding_nxt = outstanding - CNT_ONE;
    end else begin
      outstanding_nxt = outstanding;
    end
    // Everything still in flight at a redirect belongs to the old path
    if (pcselE) begin
      drop_cnt_nxt = outstanding - (imem_rsp_valid ? CNT_ONE : CNT_ZERO);
    end else if (imem_rsp_valid && (drop_cnt != CNT_ZERO)) begin
      drop_cnt_nxt = drop_cnt - CNT_ONE;
    end else begin
      drop_cnt_nxt = drop_cnt;
    end
  end

  // Fetch-side state: request PC, response tag PC and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcF         <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= CNT_ZERO;
      drop_cnt    <= CNT_ZERO;
    end else begin
      outstanding <= outstanding_nxt;
      drop_cnt    <= drop_cnt_nxt;
      if (pcselE) begin
        pcF    <= target_aligned;
        rsp_pc <= target_aligned;
      end else begin
        if (accept) pcF    <= pcF + PC_STEP;
        if (push)   rsp_pc <= rsp_pc + PC_STEP;
      end
    end
  end

  // Decode register next state: redirect/flush bubble, stall hold, pop, or bubble
  always_comb begin
    instr_nxt = instrD;
    pc_nxt    = pcD;
    pc4_nxt   = pc4D;
    valid_nxt = validD;
    if (pcselE || (flushD && !stallD)) begin
      instr_nxt = BUBBLE;
      pc_nxt    = PC_ZERO;
      pc4_nxt   = PC_ZERO;
      valid_nxt = 1'b0;
    end else if (stallD) begin
      instr_nxt = instrD;
      pc_nxt    = pcD;
      pc4_nxt   = pc4D;
      valid_nxt = validD;
    end else if (!fifo_empty) begin
      instr_nxt = head_entry.instr;
      pc_nxt    = head_entry.pc;
      pc4_nxt   = head_entry.pc + PC_STEP;
      valid_nxt = 1'b1;
    end else begin
      instr_nxt = BUBBLE;
      pc_nxt    = PC_ZERO;
      pc4_nxt   = PC_ZERO;
      valid_nxt = 1'b0;
    end
  end

  // Decode register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instrD <= BUBBLE;
      pcD    <= PC_ZERO;
      pc4D   <= PC_ZERO;
      validD <= 1'b0;
    end else begin
      instrD <= instr_nxt;
      pcD    <= pc_nxt;
      pc4D   <= pc4_nxt;
      validD <= valid_nxt;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (pcselE),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed, table-driven bench for fetch_prefetch with an in-order
// fixed-latency instruction memory model.
module tb_fetch_prefetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pcselE;
  logic [31:0] pcTargetE;
  logic        stallF, stallD, flushD;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] pcF, instrD, pcD, pc4D;
  logic        validD;

  int errors = 0;
  int checks = 0;
  int lat = 1;
  logic [31:0] mq_addr[$];
  int          mq_rem[$];

  always #5 clk = ~clk;

  fetch_prefetch #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .pcselE(pcselE), .pcTargetE(pcTargetE),
    .stallF(stallF), .stallD(stallD), .flushD(flushD),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .pcF(pcF), .instrD(instrD),
    .pcD(pcD), .pc4D(pc4D), .validD(validD)
  );

  typedef struct {
    logic        stall_d, flush_d, stall_f, ready;
    logic [31:0] exp_pcf;
    logic        exp_valid;
    logic [31:0] exp_pcd;
    logic        exp_rv;
  } vec_t;

  vec_t tbl[19];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic vec_t mk(input logic sd, input logic fd, input logic sf, input logic rd,
                              input logic [31:0] pf, input logic v, input logic [31:0] pd,
                              input logic rv);
    vec_t r;
    r.stall_d = sd; r.flush_d = fd; r.stall_f = sf; r.ready = rd;
    r.exp_pcf = pf; r.exp_valid = v; r.exp_pcd = pd; r.exp_rv = rv;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_rsp();
    if (mq_addr.size() > 0 && mq_rem[0] == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq_addr[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  endtask

  // Called at a negedge with inputs applied; returns at the following negedge
  task automatic cycle();
    logic acc, rv;
    logic [31:0] a;
    #1;
    acc = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    rv  = imem_rsp_valid;
    @(posedge clk);
    if (rv) begin
      mq_addr.delete(0);
      mq_rem.delete(0);
    end
    foreach (mq_rem[i]) if (mq_rem[i] > 0) mq_rem[i]--;
    if (acc) begin
      mq_addr.push_back(a);
      mq_rem.push_back(lat - 1);
    end
    @(negedge clk);
    drive_rsp();
  endtask

  task automatic set_in(input logic sd, input logic fd, input logic sf, input logic rd);
    stallD = sd; flushD = fd; stallF = sf; imem_req_ready = rd;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pcselE = 1'b0; pcTargetE = 32'h0;
    set_in(1'b0, 1'b0, 1'b0, 1'b1);
    mq_addr.delete();
    mq_rem.delete();
    drive_rsp();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_decode(input string tag, input logic v, input logic [31:0] pd);
    chk({tag, " validD"}, {31'h0, validD}, {31'h0, v});
    chk({tag, " pcD"}, pcD, pd);
    chk({tag, " pc4D"}, pc4D, v ? pd + 32'd4 : 32'h0);
    chk({tag, " instrD"}, instrD, v ? mem_word(pd) : 32'h0);
  endtask

  initial begin
    int n;
    bit found;

    tbl[0]  = mk(0,0,0,1, 32'h04, 0, 32'h00, 1);
    tbl[1]  = mk(0,0,0,1, 32'h08, 0, 32'h00, 1);
    tbl[2]  = mk(0,0,0,1, 32'h0C, 1, 32'h00, 1);
    tbl[3]  = mk(0,0,0,1, 32'h10, 1, 32'h04, 1);
    tbl[4]  = mk(1,0,0,1, 32'h14, 1, 32'h04, 1);
    tbl[5]  = mk(1,0,0,1, 32'h18, 1, 32'h04, 0);
    tbl[6]  = mk(1,0,0,1, 32'h18, 1, 32'h04, 0);
    tbl[7]  = mk(1,0,0,1, 32'h18, 1, 32'h04, 0);
    tbl[8]  = mk(0,0,0,1, 32'h18, 1, 32'h08, 1);
    tbl[9]  = mk(0,0,0,1, 32'h1C, 1, 32'h0C, 1);
    tbl[10] = mk(0,1,0,1, 32'h20, 0, 32'h00, 0);
    tbl[11] = mk(1,1,0,1, 32'h20, 0, 32'h00, 0);
    tbl[12] = mk(0,0,0,1, 32'h20, 1, 32'h10, 1);
    tbl[13] = mk(1,1,0,1, 32'h24, 1, 32'h10, 0);
    tbl[14] = mk(0,0,0,0, 32'h24, 1, 32'h14, 1);
    tbl[15] = mk(0,0,1,1, 32'h24, 1, 32'h18, 0);
    tbl[16] = mk(0,0,0,1, 32'h28, 1, 32'h1C, 1);
    tbl[17] = mk(0,0,0,1, 32'h2C, 1, 32'h20, 1);
    tbl[18] = mk(0,0,0,1, 32'h30, 1, 32'h24, 1);

    // Reset state, including request valid held low during reset
    lat = 1;
    rst_n = 1'b0;
    pcselE = 1'b0; pcTargetE = 32'h0;
    set_in(1'b0, 1'b0, 1'b0, 1'b1);
    drive_rsp();
    @(negedge clk);
    #1;
    chk("reset req_valid", {31'h0, imem_req_valid}, 32'h0);
    chk("reset pcF", pcF, 32'h0);
    chk_decode("reset", 1'b0, 32'h0);
    do_reset();

    // Streaming, decode stall fill-up, flush and flush-under-stall
    for (int i = 0; i < 19; i++) begin
      set_in(tbl[i].stall_d, tbl[i].flush_d, tbl[i].stall_f, tbl[i].ready);
      cycle();
      chk($sformatf("row%0d pcF", i), pcF, tbl[i].exp_pcf);
      chk_decode($sformatf("row%0d", i), tbl[i].exp_valid, tbl[i].exp_pcd);
      chk($sformatf("row%0d req_valid", i), {31'h0, imem_req_valid}, {31'h0, tbl[i].exp_rv});
    end

    // Redirect overrides a decode stall; then fetch across the address wrap
    set_in(1'b1, 1'b0, 1'b0, 1'b1);
    pcselE = 1'b1; pcTargetE = 32'hFFFF_FFFE;
    #1;
    chk("redir req_valid", {31'h0, imem_req_valid}, 32'h0);
    cycle();
    pcselE = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b1);
    chk("redir pcF", pcF, 32'hFFFF_FFFC);
    chk_decode("redir", 1'b0, 32'h0);
    cycle();
    chk("wrap pcF", pcF, 32'h0);
    found = 1'b0;
    for (n = 0; n < 10 && !found; n++) begin
      cycle();
      found = validD;
    end
    chk("wrap decode seen", {31'h0, found}, 32'h1);
    chk_decode("wrap", 1'b1, 32'hFFFF_FFFC);

    // Asynchronous reset in the middle of a burst
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst pcF", pcF, 32'h0);
    chk("midrst req_valid", {31'h0, imem_req_valid}, 32'h0);
    chk_decode("midrst", 1'b0, 32'h0);
    @(negedge clk);
    do_reset();

    // Memory not ready: no progress, no responses, bubbles in decode
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk($sformatf("nordy%0d pcF", i), pcF, 32'h0);
      chk($sformatf("nordy%0d rsp", i), {31'h0, imem_rsp_valid}, 32'h0);
      chk_decode($sformatf("nordy%0d", i), 1'b0, 32'h0);
    end
    imem_req_ready = 1'b1;
    repeat (3) cycle();
    chk_decode("resume", 1'b1, 32'h0);

    // Redirect with three requests in flight at latency 3
    @(negedge clk);
    lat = 3;
    do_reset();
    repeat (3) cycle();
    pcselE = 1'b1; pcTargetE = 32'h0000_0103;
    cycle();
    pcselE = 1'b0;
    chk("drop pcF", pcF, 32'h100);
    #1;
    chk("drop req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("drop req_addr", imem_req_addr, 32'h100);
    found = 1'b0;
    for (n = 0; n < 20 && !found; n++) begin
      cycle();
      found = validD;
    end
    chk("drop decode seen", {31'h0, found}, 32'h1);
    chk_decode("drop first", 1'b1, 32'h100);
    cycle();
    chk_decode("drop second", 1'b1, 32'h104);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
